// File: rtl/scale_gen_pipe.sv
// Multi-lane 2-stage pre-scale generator (gemm/div/exp/log) with valid/ready back-pressure.
// Define SCALE_LUT_PROG_EN to make the exp LUT writable flops instead of a constant ROM.
`timescale 1ns/1ps
module scale_gen_pipe #(
  parameter int MUL_BW = 16,
  parameter int FRA_BW = 10,
  parameter int INT_BW = 5,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                gemm_uno,
  input  logic [LANES*MUL_BW-1:0]   x_i,
  input  logic [LANES*MUL_BW-1:0]   y_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*MUL_BW-1:0]   scale_o,
  output logic [LANES-1:0]          div0_o
`ifdef SCALE_LUT_PROG_EN
  ,
  input  logic                      lut_wr_en,
  input  logic [INT_BW-1:0]         lut_wr_addr,
  input  logic [MUL_BW-1:0]         lut_wr_data
`endif
);

  localparam int DEPTH = 1 << INT_BW;
  localparam int EW    = $clog2(MUL_BW) + 1;
  localparam int WW    = MUL_BW + FRA_BW;
  localparam logic [MUL_BW-1:0] MAX_POS = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic [MUL_BW-1:0] MAX_NEG = {1'b1, {(MUL_BW-1){1'b0}}};
  localparam logic [1:0] MODE_GEMM = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_EXP  = 2'b10;
  localparam logic [1:0] MODE_LOG  = 2'b11;

  // round(e^k * 2^FRA_BW), clamped to [0, max positive]
  function automatic logic [MUL_BW-1:0] exp_default(input int k);
    real r;
    logic [MUL_BW-1:0] res;
    r = $exp($itor(k)) * $itor(1 << FRA_BW);
    if (r >= $itor((1 << (MUL_BW-1)) - 1)) res = MAX_POS;
    else if (r < 0.5)                       res = '0;
    else                                    res = MUL_BW'($rtoi(r + 0.5));
    exp_default = res;
  endfunction

  logic [MUL_BW-1:0] lut [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_lut
    localparam logic [MUL_BW-1:0] DEF = exp_default((g >= DEPTH/2) ? g - DEPTH : g);
`ifdef SCALE_LUT_PROG_EN
    logic [MUL_BW-1:0] entry_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                              entry_q <= DEF;
      else if (lut_wr_en && (lut_wr_addr == INT_BW'(g)))      entry_q <= lut_wr_data;
    end
    assign lut[g] = entry_q;
`else
    assign lut[g] = DEF;
`endif
  end

  logic                         s1_valid_q;
  logic [1:0]                   s1_mode_q;
  logic [LANES-1:0][EW-1:0]     s1_e_d, s1_e_q;
  logic [LANES-1:0][INT_BW-1:0] s1_idx_d, s1_idx_q;
  logic [LANES-1:0]             s1_zero_d, s1_zero_q;
  logic [LANES*MUL_BW-1:0]      s1_y_q;
  logic                         out_valid_q;
  logic [LANES*MUL_BW-1:0]      scale_d, scale_q;
  logic [LANES-1:0]             div0_d, div0_q;
  logic                         s2_en;

  // S2 can take a new beat when empty or being consumed this cycle
  assign s2_en    = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_en;

  always_comb begin : s1_decode
    logic [MUL_BW-1:0] x, m;
    int p;
    x = '0;
    m = '0;
    p = 0;
    s1_e_d    = '0;
    s1_idx_d  = '0;
    s1_zero_d = '0;
    for (int l = 0; l < LANES; l++) begin
      x = x_i[l*MUL_BW +: MUL_BW];
      if (x == MAX_NEG)      m = MAX_POS;
      else if (x[MUL_BW-1])  m = ~x + MUL_BW'(1);
      else                   m = x;
      p = 0;
      for (int b = 0; b < MUL_BW; b++) if (m[b]) p = b;
      s1_e_d[l]    = EW'(p - (FRA_BW - 1));
      s1_idx_d[l]  = x[FRA_BW+INT_BW-1 : FRA_BW];
      s1_zero_d[l] = (m == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      s1_e_q     <= '0;
      s1_idx_q   <= '0;
      s1_zero_q  <= '0;
      s1_y_q     <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= gemm_uno;
        s1_e_q    <= s1_e_d;
        s1_idx_q  <= s1_idx_d;
        s1_zero_q <= s1_zero_d;
        s1_y_q    <= y_i;
      end
    end
  end

  always_comb begin : s2_compute
    logic [MUL_BW-1:0] y;
    logic [EW-1:0]     e, sl;
    logic [WW-1:0]     wide;
    y       = '0;
    e       = '0;
    sl      = '0;
    wide    = '0;
    scale_d = '0;
    div0_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      y = s1_y_q[l*MUL_BW +: MUL_BW];
      e = s1_e_q[l];
      case (s1_mode_q)
        MODE_GEMM: scale_d[l*MUL_BW +: MUL_BW] = '0;
        MODE_LOG:  scale_d[l*MUL_BW +: MUL_BW] = '1;
        MODE_EXP:  scale_d[l*MUL_BW +: MUL_BW] = lut[s1_idx_q[l]];
        MODE_DIV: begin
          if (s1_zero_q[l]) begin
            div0_d[l] = 1'b1;
          end else if (!e[EW-1]) begin
            scale_d[l*MUL_BW +: MUL_BW] = $signed(y) >>> e;
          end else begin
            // widen, shift left, then saturate if bits above the sign were lost
            sl   = ~e + EW'(1);
            wide = {{FRA_BW{y[MUL_BW-1]}}, y} << sl;
            if ((&wide[WW-1:MUL_BW-1]) || ~(|wide[WW-1:MUL_BW-1]))
              scale_d[l*MUL_BW +: MUL_BW] = wide[MUL_BW-1:0];
            else
              scale_d[l*MUL_BW +: MUL_BW] = wide[WW-1] ? MAX_NEG : MAX_POS;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      scale_q     <= '0;
      div0_q      <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        scale_q <= scale_d;
        div0_q  <= div0_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign scale_o   = scale_q;
  assign div0_o    = div0_q;

endmodule
